// File: rtl/bin2ascii_digits_if.sv
// rtl/bin2ascii_digits_if.sv - conversion request and digit readout bundle
interface bin2ascii_digits_if;
  logic [13:0] value;
  logic        start;
  logic [1:0]  digit_sel;
  logic [7:0]  ascii;
  logic        busy;
  logic        done;
  logic        ovf;

  modport master (output value, start, digit_sel, input ascii, busy, done, ovf);
  modport slave  (input value, start, digit_sel, output ascii, busy, done, ovf);
endinterface

// File: rtl/bin2ascii_digits.sv
// rtl/bin2ascii_digits.sv - sequential double-dabble 14-bit to four ASCII digits
// Held digits change only on the FORMAT edge so a scanning display never tears.
module bin2ascii_digits #(
  parameter bit         LZ_BLANK   = 1'b1,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input logic               clk,
  input logic               rst,
  bin2ascii_digits_if.slave io
);

  typedef enum logic [1:0] {IDLE, SHIFT, FORMAT, DONE} state_t;

  localparam logic [7:0] LEAD_RST = LZ_BLANK ? BLANK_CHAR : 8'h30;

  state_t      state;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic [15:0] bcd_adj;
  logic [3:0]  cnt;
  logic        ovf_pend;
  logic [7:0]  d3, d2, d1, d0;
  logic        busy_r, done_r, ovf_r;
  logic        lz3, lz2, lz1;
  logic [7:0]  ascii_mux;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  // A position blanks only if every more significant position is also zero.
  always_comb begin
    lz3 = LZ_BLANK && (bcd[15:12] == 4'd0);
    lz2 = lz3 && (bcd[11:8] == 4'd0);
    lz1 = lz2 && (bcd[7:4] == 4'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ovf_r    <= 1'b0;
      d3       <= LEAD_RST;
      d2       <= LEAD_RST;
      d1       <= LEAD_RST;
      d0       <= 8'h30;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (io.start) begin
            if (io.value > 14'd9999) begin
              bin      <= 14'd9999;
              ovf_pend <= 1'b1;
            end else begin
              bin      <= io.value;
              ovf_pend <= 1'b0;
            end
            bcd    <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          bcd <= {bcd_adj[14:0], bin[13]};
          bin <= {bin[12:0], 1'b0};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd13)
            state <= FORMAT;
        end
        FORMAT: begin
          d3     <= lz3 ? BLANK_CHAR : {4'h3, bcd[15:12]};
          d2     <= lz2 ? BLANK_CHAR : {4'h3, bcd[11:8]};
          d1     <= lz1 ? BLANK_CHAR : {4'h3, bcd[7:4]};
          d0     <= {4'h3, bcd[3:0]};
          ovf_r  <= ovf_pend;
          done_r <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (io.digit_sel)
      2'd0:    ascii_mux = d0;
      2'd1:    ascii_mux = d1;
      2'd2:    ascii_mux = d2;
      default: ascii_mux = d3;
    endcase
  end

  assign io.ascii = ascii_mux;
  assign io.busy  = busy_r;
  assign io.done  = done_r;
  assign io.ovf   = ovf_r;

endmodule

// File: tb/tb_bin2ascii_digits.sv
// tb/tb_bin2ascii_digits.sv - directed vector bench for bin2ascii_digits
module tb_bin2ascii_digits;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bin2ascii_digits_if bus0 ();
  bin2ascii_digits_if bus1 ();

  bin2ascii_digits #(.LZ_BLANK(1'b1), .BLANK_CHAR(8'h20)) dut (.clk(clk), .rst(rst), .io(bus0.slave));
  bin2ascii_digits #(.LZ_BLANK(1'b0), .BLANK_CHAR(8'h20)) dut_nz (.clk(clk), .rst(rst), .io(bus1.slave));

  typedef struct {
    logic [13:0] value;
    logic [31:0] digits;
    logic        ovf;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic read_digits(input bit which, output logic [31:0] d);
    d = '0;
    for (int i = 3; i >= 0; i--) begin
      if (which) bus1.digit_sel = 2'(i);
      else       bus0.digit_sel = 2'(i);
      #1;
      d = {d[23:0], which ? bus1.ascii : bus0.ascii};
    end
  endtask

  task automatic start_conv(input logic [13:0] v);
    bus0.value = v;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus0.done && n < 40) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(bus0.done), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    int          ndone;
    int          done_at;
    int          done_at2;

    vecs[0] = '{14'd7,     32'h20202037, 1'b0};
    vecs[1] = '{14'd0,     32'h20202030, 1'b0};
    vecs[2] = '{14'd1005,  32'h31303035, 1'b0};
    vecs[3] = '{14'd12000, 32'h39393939, 1'b1};
    vecs[4] = '{14'd42,    32'h20203432, 1'b0};
    vecs[5] = '{14'd9999,  32'h39393939, 1'b0};
    vecs[6] = '{14'd100,   32'h20313030, 1'b0};
    vecs[7] = '{14'd10000, 32'h39393939, 1'b1};
    vecs[8] = '{14'd16383, 32'h39393939, 1'b1};

    bus0.value = '0; bus0.start = 1'b0; bus0.digit_sel = '0;
    bus1.value = '0; bus1.start = 1'b0; bus1.digit_sel = '0;

    // reset state
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", 32'(bus0.busy), 32'd0);
    chk("rst_done", 32'(bus0.done), 32'd0);
    chk("rst_ovf",  32'(bus0.ovf),  32'd0);
    read_digits(1'b0, d);
    chk("rst_digits", d, 32'h20202030);
    read_digits(1'b1, d);
    chk("rst_digits_nz", d, 32'h30303030);

    // 1234 with exact latency
    start_conv(14'd1234);
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("lat_busy_%0d", k), 32'(bus0.busy), 32'd1);
      chk($sformatf("lat_done_%0d", k), 32'(bus0.done), (k == 16) ? 32'd1 : 32'd0);
      if (k == 15) begin
        read_digits(1'b0, d);
        chk("lat_hold_n15", d, 32'h20202030);
      end
      if (k == 16) begin
        read_digits(1'b0, d);
        chk("lat_digits_n16", d, 32'h31323334);
        chk("lat_ovf", 32'(bus0.ovf), 32'd0);
      end
      tick();
    end
    chk("lat_busy_n17", 32'(bus0.busy), 32'd0);
    chk("lat_done_n17", 32'(bus0.done), 32'd0);

    // table of values
    foreach (vecs[i]) begin
      start_conv(vecs[i].value);
      wait_done();
      read_digits(1'b0, d);
      chk($sformatf("vec%0d_digits", i), d, vecs[i].digits);
      chk($sformatf("vec%0d_ovf", i), 32'(bus0.ovf), 32'(vecs[i].ovf));
      tick();
    end

    // second start while busy is dropped
    start_conv(14'd4000);
    ndone = 0; done_at = 0;
    for (int k = 1; k <= 20; k++) begin
      bus0.start = (k == 5);
      bus0.value = (k == 5) ? 14'd1111 : 14'd4000;
      if (bus0.done) begin
        ndone++;
        done_at = k;
      end
      tick();
    end
    bus0.start = 1'b0;
    chk("drop_ndone", 32'(ndone), 32'd1);
    chk("drop_done_at", 32'(done_at), 32'd16);
    read_digits(1'b0, d);
    chk("drop_digits", d, 32'h34303030);

    // set ovf so the reset abort has something to clear
    start_conv(14'd16383);
    wait_done();
    tick();

    // reset mid-conversion
    start_conv(14'd4321);
    for (int k = 1; k < 8; k++) tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus0.busy), 32'd0);
    chk("abort_done", 32'(bus0.done), 32'd0);
    chk("abort_ovf",  32'(bus0.ovf),  32'd0);
    read_digits(1'b0, d);
    chk("abort_digits", d, 32'h20202030);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus0.done) ndone++;
      tick();
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    start_conv(14'd4321);
    wait_done();
    read_digits(1'b0, d);
    chk("abort_redo_digits", d, 32'h34333231);
    chk("abort_redo_ovf", 32'(bus0.ovf), 32'd0);
    tick();

    // held start retriggers every 17 cycles
    bus0.value = 14'd55;
    bus0.start = 1'b1;
    tick();
    done_at = 0; done_at2 = 0;
    for (int k = 1; k <= 34; k++) begin
      if (bus0.done) begin
        if (done_at == 0) done_at = k;
        else              done_at2 = k;
      end
      tick();
    end
    bus0.start = 1'b0;
    chk("held_first_done", 32'(done_at), 32'd16);
    chk("held_second_done", 32'(done_at2), 32'd33);
    wait_done();
    read_digits(1'b0, d);
    chk("held_digits", d, 32'h20203535);
    tick();

    // leading zeros kept
    bus1.value = 14'd42;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    ndone = 0;
    while (!bus1.done && ndone < 40) begin
      tick();
      ndone++;
    end
    chk("nz_done_seen", 32'(bus1.done), 32'd1);
    read_digits(1'b1, d);
    chk("nz_digits", d, 32'h30303432);
    chk("nz_ovf", 32'(bus1.ovf), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
